// File: rtl/if_fetch_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry first-word-fall-through FIFO of
// {pc, instruction} pairs with valid/ready on both sides and a redirect flush.
module if_fetch_queue #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013,
    parameter int              CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_instr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [XLEN-1:0]  pc_mem_r    [DEPTH];
    logic [XLEN-1:0]  instr_mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    // Flags come only from the registered count, so in_ready never sees out_ready.
    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;

    // Entry storage; contents are don't-care until the count covers them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]    <= in_pc;
            instr_mem_r[wr_ptr_r] <= in_instr;
        end
    end

    // Pointer and occupancy update; reset beats flush, flush beats both handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head presentation: an empty queue shows a NOP bubble, never stale storage.
    always_comb begin
        out_pc    = {XLEN{1'b0}};
        out_instr = NOP_INSTR;
        if (!empty) begin
            out_pc    = pc_mem_r[rd_ptr_r];
            out_instr = instr_mem_r[rd_ptr_r];
        end else begin
            out_pc    = {XLEN{1'b0}};
            out_instr = NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: reset, fill/drain, wrap, stall, flush and
// mid-stream reset, each against hand-computed expectations.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready, full, empty;
    logic [31:0] in_pc, in_instr, out_pc, out_instr;
    logic [2:0]  count;

    int checks_cnt = 0;
    int errors_cnt = 0;

    always #5 clk = ~clk;

    if_fetch_queue dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pc    (in_pc),
        .in_instr (in_instr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc   (out_pc),
        .out_instr(out_instr),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic rdy);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = rdy;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b1, 32'h999, 32'hDEAD, 1'b0);
        step();
        step();
        // Reset then idle
        check_eq("rst_count", count, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_instr", out_instr, 32'h13);
        check_eq("rst_out_pc", out_pc, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        step();
        check_eq("idle_count", count, 0);

        // Fill and drain
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
            step();
            check_eq("fill_count", count, 64'(i + 1));
            check_eq("fill_head_pc", out_pc, 32'h100);
        end
        check_eq("fill_full", full, 1);
        check_eq("fill_in_ready", in_ready, 0);
        drive(1'b1, 32'h110, 32'hA4, 1'b0);
        step();
        check_eq("drop5_count", count, 4);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        check_eq("full_pop_in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_pc", out_pc, 32'h100 + 32'(4 * i));
            check_eq("drain_instr", out_instr, 32'hA0 + 32'(i));
            step();
        end
        check_eq("drain_empty", empty, 1);
        check_eq("drain_nop", out_instr, 32'h13);
        check_eq("drain_pc0", out_pc, 0);

        // Wrap-around with count held at 2
        drive(1'b1, 32'h500, 32'hB0, 1'b0);
        step();
        drive(1'b1, 32'h504, 32'hB1, 1'b0);
        step();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h508 + 32'(4 * k), 32'hB2 + 32'(k), 1'b1);
            check_eq("wrap_pc", out_pc, 32'h500 + 32'(4 * k));
            check_eq("wrap_instr", out_instr, 32'hB0 + 32'(k));
            check_eq("wrap_count", count, 2);
            step();
        end
        check_eq("wrap_count_end", count, 2);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        for (int k = 10; k < 12; k++) begin
            check_eq("wrap_tail_pc", out_pc, 32'h500 + 32'(4 * k));
            step();
        end
        check_eq("wrap_empty", empty, 1);

        // Decode stall: head must hold while more entries arrive
        drive(1'b1, 32'h200, 32'hC0, 1'b0);
        step();
        drive(1'b1, 32'h204, 32'hC1, 1'b0);
        check_eq("stall_pc0", out_pc, 32'h200);
        step();
        drive(1'b1, 32'h208, 32'hC2, 1'b0);
        check_eq("stall_pc1", out_pc, 32'h200);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        check_eq("stall_pc2", out_pc, 32'h200);
        check_eq("stall_instr", out_instr, 32'hC0);
        step();
        check_eq("stall_pc3", out_pc, 32'h200);
        check_eq("stall_count", count, 3);

        // Flush with simultaneous push and pop
        flush = 1'b1;
        drive(1'b1, 32'h300, 32'hD0, 1'b1);
        check_eq("flush_cycle_in_ready", in_ready, 1);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        check_eq("flush_count", count, 0);
        check_eq("flush_empty", empty, 1);
        check_eq("flush_nop", out_instr, 32'h13);
        check_eq("flush_pc0", out_pc, 0);
        drive(1'b1, 32'h304, 32'hD1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        check_eq("post_flush_pc", out_pc, 32'h304);
        check_eq("post_flush_count", count, 1);
        step();
        check_eq("post_flush_empty", empty, 1);

        // Reset mid-operation with a full queue
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h600 + 32'(4 * i), 32'hE0 + 32'(i), 1'b0);
            step();
        end
        check_eq("pre_rst_full", full, 1);
        reset = 1'b1;
        flush = 1'b1;
        drive(1'b1, 32'h6FF, 32'hEF, 1'b1);
        step();
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b1, 32'h400, 32'hF0, 1'b0);
        check_eq("midrst_count", count, 0);
        check_eq("midrst_empty", empty, 1);
        check_eq("midrst_nop", out_instr, 32'h13);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        check_eq("midrst_head_pc", out_pc, 32'h400);
        check_eq("midrst_head_instr", out_instr, 32'hF0);
        check_eq("midrst_head_count", count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry FIFO of {pc, instruction} pairs between fetch and decode.
- Valid/ready handshake on both sides replaces the single stall input; the flush input discards every queued entry.
- When the queue is empty, decode sees a NOP bubble, so the fetch unit can run ahead of decode stalls.

Parameters:
- XLEN, 32, width of PC and instruction.
- DEPTH, 4, number of entries; power of two, at least 2.
- NOP_INSTR, 32'h00000013, instruction presented when empty (ADDI x0,x0,0).
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk, in, 1, rising-edge clock.
- reset, in, 1, synchronous active-high reset.
- flush, in, 1, discards all entries (branch/jump redirect).
- in_valid, in, 1, fetch presents an entry.
- in_ready, out, 1, queue can accept an entry; equals !full.
- in_pc, in, XLEN, PC of the fetched instruction.
- in_instr, in, XLEN, fetched instruction word.
- out_valid, out, 1, head entry valid; equals !empty.
- out_ready, in, 1, decode consumes the head (0 = decode stall).
- out_pc, out, XLEN, head PC, or 0 when empty.
- out_instr, out, XLEN, head instruction, or NOP_INSTR when empty.
- count, out, CNT_W, number of occupied entries, 0..DEPTH.
- full, out, 1, count==DEPTH.
- empty, out, 1, count==0.

Behaviour:
- One clock domain. Reset is synchronous and active-high: clock port clk, reset port reset. All state changes only on the rising edge of clk.
- Reset (reset=1 at posedge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Outputs then read: empty=1, full=0, in_ready=1, out_valid=0, out_pc=0, out_instr=NOP_INSTR.
  - Storage contents are don't-care.
  - Reset has priority over flush and both handshakes, including mid-stream with the queue full.
- Push occurs when in_valid && in_ready. The entry is written at wr_ptr, and wr_ptr increments modulo DEPTH (natural wrap at log2(DEPTH) bits).
- Pop occurs when out_valid && out_ready. rd_ptr increments modulo DEPTH.
- Handshake rules:
  - in_ready depends only on registered state, with no combinational path from out_ready. A push is therefore refused when full, even if a pop happens in the same cycle.
  - in_valid with in_ready=0 is ignored. The fetch unit holds its data and the queue does not latch it.
  - out_ready while empty has no effect.
- Simultaneous push and pop (0<count<DEPTH): count is unchanged and both pointers advance.
- First-word fall-through:
  - out_pc/out_instr are driven combinationally from storage[rd_ptr] when !empty.
  - An entry pushed in cycle N is visible at the outputs in cycle N+1. Write-to-read latency is 1 cycle, and there is no same-cycle bypass.
  - When empty, the outputs are the constants 0 / NOP_INSTR.
- Head stability: while out_valid=1 and out_ready=0, out_pc and out_instr remain stable across cycles.
- Flush (reset=0, flush=1):
  - At the edge: rd_ptr<=wr_ptr and count<=0.
  - Any same-cycle push and pop are discarded (flush wins).
  - In the next cycle: empty=1 and out_instr=NOP_INSTR.
  - in_ready is still driven as !full during the flush cycle. The fetch unit must treat its flush-cycle handshake as dropped.
- Flags: full, empty and count are derived from the registered count. They are never simultaneously 1 (DEPTH ≥ 2).
- No X propagation: out_pc and out_instr never expose uninitialised storage, because empty forces the constants.

Test Plan:
- Reset then idle: assert reset 2 cycles with in_valid=1 → count=0, out_valid=0, out_instr=0x00000013, out_pc=0, in_ready=1.
- Fill and drain: out_ready=0; push pc 0x100,0x104,0x108,0x10C with instr 0xA0..0xA3 → full=1, in_ready=0. A fifth push (pc 0x110) is dropped. With out_ready=1, pops return 0x100..0x10C in order, then empty=1.
- Wrap-around: 10 cycles of continuous push+pop with count held at 2 → pointers wrap past DEPTH. Output order equals input order, no loss or duplicate, count stays 2.
- Decode stall: queue holds pc 0x200 at head; out_ready=0 for 3 cycles while pushing 0x204,0x208 → out_pc remains 0x200 throughout, count reaches 3.
- Flush with simultaneous traffic: count=3; in one cycle assert flush, in_valid (pc 0x300) and out_ready → next cycle count=0, out_instr=0x00000013. The 0x300 entry never appears.
- Reset mid-operation: full queue and reset=1 with in_valid=1, out_ready=1 → next cycle count=0, empty=1. The first push after reset (pc 0x400) appears at the head one cycle later.
